uart_receiver: RTL and testbench

- UART receive stage. It consumes the serial line that the transmitter drives (Tx → rx in loopback, or an external pin).
- Recovers 8N1 frames using a 16x oversampling enable and presents each byte on a parallel output with a ready/clear handshake.
- Shares the 50 MHz system clock with the transmitter. The shared baud generator supplies the oversampling tick.

---
 rtl/uart_receiver.sv | 171 +++++++++++++++++
 tb/tb_uart_receiver.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_receiver.sv
// 8N1 UART receive stage driven by an OVERSAMPLE x baud enable.
// It recovers framed bytes and presents them through a rdy/rdy_clr handshake.
module uart_receiver #(
    parameter int OVERSAMPLE = 16,
    parameter int DATA_BITS  = 8
) (
    input  logic                 clk_50m,
    input  logic                 rst_n,
    input  logic                 rx,
    input  logic                 clken,
    input  logic                 rdy_clr,
    output logic [DATA_BITS-1:0] data_out,
    output logic                 rdy,
    output logic                 frame_err,
    output logic                 overrun,
    output logic                 rx_busy
);
    localparam int SAMPLE_W = $clog2(OVERSAMPLE);
    localparam int POS_W    = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

    localparam logic [SAMPLE_W-1:0] HALF_LAST = SAMPLE_W'(OVERSAMPLE / 2 - 1);
    localparam logic [SAMPLE_W-1:0] FULL_LAST = SAMPLE_W'(OVERSAMPLE - 1);
    localparam logic [POS_W-1:0]    LAST_POS  = POS_W'(DATA_BITS - 1);

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_START = 3'd1;
    localparam logic [2:0] ST_DATA  = 3'd2;
    localparam logic [2:0] ST_STOP  = 3'd3;
    localparam logic [2:0] ST_BREAK = 3'd4;

    logic                 rx_meta_reg, rx_s_reg;
    logic [2:0]           state_reg, state_next;
    logic [SAMPLE_W-1:0]  sample_reg, sample_next;
    logic [POS_W-1:0]     bit_pos_reg, bit_pos_next;
    logic [DATA_BITS-1:0] shift_reg, shift_next;
    logic [DATA_BITS-1:0] data_reg, data_next;
    logic                 rdy_reg, rdy_next;
    logic                 frame_err_reg, frame_err_next;
    logic                 overrun_reg, overrun_next;
    logic [DATA_BITS-1:0] bit_sel;

    // One-hot mask of the payload bit currently being captured
    genvar gi;
    generate
        for (gi = 0; gi < DATA_BITS; gi++) begin : g_bit_sel
            assign bit_sel[gi] = (bit_pos_reg == POS_W'(gi));
        end
    endgenerate

    always_ff @(posedge clk_50m) begin
        if (!rst_n) begin
            rx_meta_reg <= 1'b1;
            rx_s_reg    <= 1'b1;
        end else begin
            rx_meta_reg <= rx;
            rx_s_reg    <= rx_meta_reg;
        end
    end

    always_comb begin
        state_next     = state_reg;
        sample_next    = sample_reg;
        bit_pos_next   = bit_pos_reg;
        shift_next     = shift_reg;
        data_next      = data_reg;
        rdy_next       = rdy_reg;
        frame_err_next = frame_err_reg;
        overrun_next   = overrun_reg;

        if (rdy_clr) begin
            rdy_next     = 1'b0;
            overrun_next = 1'b0;
        end

        case (state_reg)
            ST_IDLE: begin
                if (clken && !rx_s_reg) begin
                    state_next  = ST_START;
                    sample_next = '0;
                end
            end
            ST_START: begin
                if (clken) begin
                    if (sample_reg == HALF_LAST) begin
                        if (!rx_s_reg) begin
                            state_next   = ST_DATA;
                            sample_next  = '0;
                            bit_pos_next = '0;
                        end else begin
                            state_next = ST_IDLE;
                        end
                    end else begin
                        sample_next = sample_reg + 1'b1;
                    end
                end
            end
            ST_DATA: begin
                if (clken) begin
                    if (sample_reg == FULL_LAST) begin
                        shift_next  = (shift_reg & ~bit_sel) | ({DATA_BITS{rx_s_reg}} & bit_sel);
                        sample_next = '0;
                        if (bit_pos_reg == LAST_POS) begin
                            state_next = ST_STOP;
                        end else begin
                            bit_pos_next = bit_pos_reg + 1'b1;
                        end
                    end else begin
                        sample_next = sample_reg + 1'b1;
                    end
                end
            end
            ST_STOP: begin
                if (clken) begin
                    if (sample_reg == FULL_LAST) begin
                        sample_next = '0;
                        if (rx_s_reg) begin
                            // A new byte beats a simultaneous acknowledge
                            data_next      = shift_reg;
                            rdy_next       = 1'b1;
                            frame_err_next = 1'b0;
                            overrun_next   = rdy_clr ? 1'b0 : (overrun_reg | rdy_reg);
                            state_next     = ST_IDLE;
                        end else begin
                            frame_err_next = 1'b1;
                            state_next     = ST_BREAK;
                        end
                    end else begin
                        sample_next = sample_reg + 1'b1;
                    end
                end
            end
            ST_BREAK: begin
                if (rx_s_reg) begin
                    state_next = ST_IDLE;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_50m) begin
        if (!rst_n) begin
            state_reg     <= ST_IDLE;
            sample_reg    <= '0;
            bit_pos_reg   <= '0;
            shift_reg     <= '0;
            data_reg      <= '0;
            rdy_reg       <= 1'b0;
            frame_err_reg <= 1'b0;
            overrun_reg   <= 1'b0;
        end else begin
            state_reg     <= state_next;
            sample_reg    <= sample_next;
            bit_pos_reg   <= bit_pos_next;
            shift_reg     <= shift_next;
            data_reg      <= data_next;
            rdy_reg       <= rdy_next;
            frame_err_reg <= frame_err_next;
            overrun_reg   <= overrun_next;
        end
    end

    assign data_out  = data_reg;
    assign rdy       = rdy_reg;
    assign frame_err = frame_err_reg;
    assign overrun   = overrun_reg;
    assign rx_busy   = (state_reg != ST_IDLE);

endmodule

// File: tb/tb_uart_receiver.sv
// Directed and randomized frames against a per-frame reference model of the
// receiver's visible outputs (byte, rdy, frame_err, overrun, busy timing).
module tb_uart_receiver;
    logic       clk_50m = 1'b0;
    logic       rst_n;
    logic       rx;
    logic       clken;
    logic       rdy_clr;
    logic [7:0] data_out;
    logic       rdy;
    logic       frame_err;
    logic       overrun;
    logic       rx_busy;

    int checks = 0;
    int errors = 0;
    int rise_cycle;

    // Reference model state
    logic [7:0] exp_data;
    logic       exp_rdy, exp_fe, exp_ovr;

    // Posedge index (counted from the frame's first negedge) at which the stop
    // bit is sampled: 2-flop sync + first tick (4), half bit (32), 9 bits of 64.
    localparam int STOP_EDGE = 4 + 32 + 9 * 64;

    uart_receiver #(.OVERSAMPLE(16), .DATA_BITS(8)) dut (
        .clk_50m  (clk_50m),
        .rst_n    (rst_n),
        .rx       (rx),
        .clken    (clken),
        .rdy_clr  (rdy_clr),
        .data_out (data_out),
        .rdy      (rdy),
        .frame_err(frame_err),
        .overrun  (overrun),
        .rx_busy  (rx_busy)
    );

    always #10 clk_50m = ~clk_50m;

    // clken: one cycle high in every four, changed on negedges
    initial begin
        int cnt;
        cnt   = 0;
        clken = 1'b0;
        forever begin
            @(negedge clk_50m);
            cnt   = (cnt + 1) % 4;
            clken = (cnt == 0);
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv)
        else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
        end
    endtask

    task automatic check_outputs(input string tag);
        check({tag, "_data"}, 32'(data_out), 32'(exp_data));
        check({tag, "_rdy"}, 32'(rdy), 32'(exp_rdy));
        check({tag, "_frame_err"}, 32'(frame_err), 32'(exp_fe));
        check({tag, "_overrun"}, 32'(overrun), 32'(exp_ovr));
    endtask

    function automatic void model_frame(input logic [7:0] b, input logic stop_ok, input logic clr_same);
        if (stop_ok) begin
            exp_ovr  = clr_same ? 1'b0 : (exp_ovr | exp_rdy);
            exp_rdy  = 1'b1;
            exp_data = b;
            exp_fe   = 1'b0;
        end else begin
            exp_fe = 1'b1;
            if (clr_same) begin
                exp_rdy = 1'b0;
                exp_ovr = 1'b0;
            end
        end
    endfunction

    function automatic void model_reset();
        exp_data = 8'h00;
        exp_rdy  = 1'b0;
        exp_fe   = 1'b0;
        exp_ovr  = 1'b0;
    endfunction

    task automatic align_to_tick();
        do @(posedge clk_50m); while (clken !== 1'b1);
    endtask

    // Drives len clocks of an 8N1 frame starting right after a clken edge.
    // rdy_clr is high only for posedge clr_at; rx is left at the last bit level.
    task automatic send_frame(input logic [7:0] b, input logic stop_bit, input int clr_at, input int len = 640);
        logic [9:0] frame;
        logic       prev_rdy;
        frame      = {stop_bit, b, 1'b0};
        rise_cycle = -1;
        align_to_tick();
        #1;
        prev_rdy = rdy;
        for (int c = 0; c < len; c++) begin
            @(negedge clk_50m);
            rx      = frame[c / 64];
            rdy_clr = (c + 1 == clr_at);
            @(posedge clk_50m);
            #1;
            if (!prev_rdy && rdy) rise_cycle = c + 1;
            prev_rdy = rdy;
        end
        @(negedge clk_50m);
        rdy_clr = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk_50m);
            rx = 1'b1;
        end
    endtask

    task automatic pulse_clr(input string tag);
        @(negedge clk_50m);
        rdy_clr = 1'b1;
        @(negedge clk_50m);
        rdy_clr = 1'b0;
        exp_rdy = 1'b0;
        exp_ovr = 1'b0;
        check_outputs(tag);
        $display("rdy_clr pulse -> rdy=%0b overrun=%0b", rdy, overrun);
    endtask

    task automatic good_frame(input string tag, input logic [7:0] b, input int clr_at);
        send_frame(b, 1'b1, clr_at);
        model_frame(b, 1'b1, clr_at == STOP_EDGE);
        idle(64);
        check_outputs(tag);
        $display("frame %02h -> data_out=%02h rdy=%0b frame_err=%0b overrun=%0b", b, data_out, rdy, frame_err, overrun);
    endtask

    initial begin
        logic [7:0] rb;
        logic       clr_same;
        rst_n   = 1'b0;
        rx      = 1'b1;
        rdy_clr = 1'b0;
        model_reset();
        repeat (4) @(negedge clk_50m);
        check_outputs("reset");
        check("reset_busy", 32'(rx_busy), 32'd0);
        rst_n = 1'b1;
        idle(16);

        // 1: basic byte with exact rdy latency
        send_frame(8'hA5, 1'b1, -1);
        model_frame(8'hA5, 1'b1, 1'b0);
        check("t1_rdy_rise_edge", 32'(rise_cycle), 32'(STOP_EDGE));
        idle(64);
        check_outputs("t1");
        $display("frame a5 -> data_out=%02h rdy=%0b rise_edge=%0d", data_out, rdy, rise_cycle);
        pulse_clr("t1_clr");

        // 2: 3-tick glitch is rejected at the mid-start sample
        align_to_tick();
        for (int c = 0; c < 60; c++) begin
            @(negedge clk_50m);
            rx = (c < 12) ? 1'b0 : 1'b1;
            @(posedge clk_50m);
            #1;
            if (c + 1 == 3)  check("t2_busy_before", 32'(rx_busy), 32'd0);
            if (c + 1 == 4)  check("t2_busy_start", 32'(rx_busy), 32'd1);
            if (c + 1 == 35) check("t2_busy_last", 32'(rx_busy), 32'd1);
            if (c + 1 == 36) check("t2_busy_after", 32'(rx_busy), 32'd0);
        end
        check_outputs("t2");
        $display("glitch -> rx_busy=%0b rdy=%0b data_out=%02h", rx_busy, rdy, data_out);
        idle(16);

        // 3: framing error, held break, then recovery
        send_frame(8'h3C, 1'b0, -1);
        model_frame(8'h3C, 1'b0, 1'b0);
        check_outputs("t3_bad");
        repeat (160) begin
            @(negedge clk_50m);
            rx = 1'b0;
        end
        check("t3_break_busy", 32'(rx_busy), 32'd1);
        check_outputs("t3_break");
        $display("frame 3c stop=0 + break -> frame_err=%0b rdy=%0b busy=%0b", frame_err, rdy, rx_busy);
        @(negedge clk_50m);
        rx = 1'b1;
        repeat (4) @(negedge clk_50m);
        check("t3_break_exit", 32'(rx_busy), 32'd0);
        idle(64);
        good_frame("t3_81", 8'h81, -1);
        pulse_clr("t3_clr");

        // 4: overrun when a byte lands on an unacknowledged one
        good_frame("t4_11", 8'h11, -1);
        good_frame("t4_22", 8'h22, -1);
        pulse_clr("t4_clr");

        // 5: acknowledge on the exact set cycle while a byte is waiting
        good_frame("t5_44", 8'h44, -1);
        good_frame("t5_55", 8'h55, STOP_EDGE);
        pulse_clr("t5_clr");

        // 6: reset in the middle of bit 4, then clean reception
        send_frame(8'hF0, 1'b1, -1, 64 * 5 + 32);
        @(negedge clk_50m);
        rst_n = 1'b0;
        rx    = 1'b1;
        model_reset();
        @(negedge clk_50m);
        check_outputs("t6_reset");
        check("t6_reset_busy", 32'(rx_busy), 32'd0);
        $display("reset mid-frame -> data_out=%02h rdy=%0b busy=%0b", data_out, rdy, rx_busy);
        @(negedge clk_50m);
        rst_n = 1'b1;
        idle(64);
        good_frame("t6_0f", 8'h0F, -1);
        pulse_clr("t6_clr0");
        good_frame("t6_00", 8'h00, -1);
        pulse_clr("t6_clr1");
        good_frame("t6_ff", 8'hFF, -1);
        pulse_clr("t6_clr2");
        good_frame("t6_6b", 8'h6B, -1);

        // Randomized bytes with random acknowledge behaviour
        for (int i = 0; i < 8; i++) begin
            rb       = 8'($urandom_range(0, 255));
            clr_same = ($urandom_range(0, 3) == 0);
            good_frame("rand", rb, clr_same ? STOP_EDGE : -1);
            if ($urandom_range(0, 1) == 1) pulse_clr("rand_clr");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
